// File: rtl/regfile_writeback.sv
// regfile_writeback: in-order write-back queue feeding the register file's
// single write port. Accepts up to two results per cycle (load, then ALU),
// drains one per cycle, and reports pending writes for two source registers.
// Optional bypass data for pending writes is enabled with the WB_BYPASS_EN macro.
module regfile_writeback #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [4:0]        ld_rd,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [4:0]        alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              hold,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [4:0]        q_rs1,
    input  logic [4:0]        q_rs2,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              rs1_fwd_valid,
    output logic [DATA_W-1:0] rs1_fwd_data,
    output logic              rs2_fwd_valid,
    output logic [DATA_W-1:0] rs2_fwd_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned RD_W  = 5;

    logic [RD_W-1:0]   ent_rd_q   [DEPTH];
    logic [RD_W-1:0]   ent_rd_d   [DEPTH];
    logic [DATA_W-1:0] ent_data_q [DEPTH];
    logic [DATA_W-1:0] ent_data_d [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              rf_we_q, rf_we_d;
    logic [RD_W-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

    logic [CNT_W-1:0]  free_c;
    logic              ld_push_c, alu_push_c, pop_c;
    logic [PTR_W-1:0]  alu_slot_c;
    logic [DEPTH-1:0]  ent_valid_c;
    logic [DEPTH-1:0]  rs1_hit_c, rs2_hit_c;
    logic              rs1_out_hit_c, rs2_out_hit_c;

    // Ready from registered occupancy only; a same-cycle pop frees nothing
    always_comb begin
        free_c    = CNT_W'(DEPTH) - count_q;
        ld_ready  = (free_c != '0);
        alu_ready = (free_c >= CNT_W'(2)) || ((free_c == CNT_W'(1)) && !ld_valid);
    end

    // Enqueue (load first, then ALU), dequeue head into the write-port register
    always_comb begin
        ent_rd_d   = ent_rd_q;
        ent_data_d = ent_data_q;
        ld_push_c  = ld_valid && ld_ready && (ld_rd != '0);
        alu_push_c = alu_valid && alu_ready && (alu_rd != '0);
        pop_c      = (count_q != '0) && !hold;
        alu_slot_c = wr_ptr_q + PTR_W'(ld_push_c);

        if (ld_push_c) begin
            ent_rd_d[wr_ptr_q]   = ld_rd;
            ent_data_d[wr_ptr_q] = ld_data;
        end
        if (alu_push_c) begin
            ent_rd_d[alu_slot_c]   = alu_rd;
            ent_data_d[alu_slot_c] = alu_data;
        end

        wr_ptr_d = wr_ptr_q + PTR_W'(ld_push_c) + PTR_W'(alu_push_c);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
        count_d  = count_q + CNT_W'(ld_push_c) + CNT_W'(alu_push_c) - CNT_W'(pop_c);

        rf_we_d    = pop_c;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (pop_c) begin
            rf_waddr_d = ent_rd_q[rd_ptr_q];
            rf_wdata_d = ent_data_q[rd_ptr_q];
        end
    end

    // State registers; reset discards all queued and in-flight writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent_rd_q[i]   <= '0;
                ent_data_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            ent_rd_q   <= ent_rd_d;
            ent_data_q <= ent_data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    // Mark occupied slots, walking from the head for count entries
    always_comb begin
        logic [PTR_W-1:0] idx;
        ent_valid_c = '0;
        idx         = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            idx = rd_ptr_q + PTR_W'(k);
            if (CNT_W'(k) < count_q) begin
                ent_valid_c[idx] = 1'b1;
            end
        end
    end

    // Per-slot and output-register match for both source registers
    always_comb begin
        rs1_hit_c = '0;
        rs2_hit_c = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            rs1_hit_c[i] = ent_valid_c[i] && (ent_rd_q[i] == q_rs1);
            rs2_hit_c[i] = ent_valid_c[i] && (ent_rd_q[i] == q_rs2);
        end
        rs1_out_hit_c = rf_we_q && (rf_waddr_q == q_rs1);
        rs2_out_hit_c = rf_we_q && (rf_waddr_q == q_rs2);
        rs1_busy      = (q_rs1 != '0) && ((|rs1_hit_c) || rs1_out_hit_c);
        rs2_busy      = (q_rs2 != '0) && ((|rs2_hit_c) || rs2_out_hit_c);
    end

`ifdef WB_BYPASS_EN
    // Youngest match wins: output register first, then head to tail overwrites
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx          = '0;
        rs1_fwd_data = '0;
        rs2_fwd_data = '0;
        if (rs1_out_hit_c) begin
            rs1_fwd_data = rf_wdata_q;
        end
        if (rs2_out_hit_c) begin
            rs2_fwd_data = rf_wdata_q;
        end
        for (int k = 0; k < int'(DEPTH); k++) begin
            idx = rd_ptr_q + PTR_W'(k);
            if (rs1_hit_c[idx]) begin
                rs1_fwd_data = ent_data_q[idx];
            end
            if (rs2_hit_c[idx]) begin
                rs2_fwd_data = ent_data_q[idx];
            end
        end
        rs1_fwd_valid = rs1_busy;
        rs2_fwd_valid = rs2_busy;
    end
`else
    assign rs1_fwd_valid = 1'b0;
    assign rs1_fwd_data  = '0;
    assign rs2_fwd_valid = 1'b0;
    assign rs2_fwd_data  = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback with a write-order scoreboard.
module tb_regfile_writeback;

    logic        clk;
    logic        reset;
    logic        ld_valid, ld_ready, alu_valid, alu_ready, hold;
    logic [4:0]  ld_rd, alu_rd, q_rs1, q_rs2, rf_waddr;
    logic [31:0] ld_data, alu_data, rf_wdata, rs1_fwd_data, rs2_fwd_data;
    logic        rf_we, rs1_busy, rs2_busy, rs1_fwd_valid, rs2_fwd_valid;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t sb[$];
    int  tests = 0;
    int  fails = 0;

    regfile_writeback #(.DEPTH(4), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .hold(hold),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .q_rs1(q_rs1), .q_rs2(q_rs2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rs1_fwd_valid(rs1_fwd_valid), .rs1_fwd_data(rs1_fwd_data),
        .rs2_fwd_valid(rs2_fwd_valid), .rs2_fwd_data(rs2_fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of results, check readiness, record expected writes
    task automatic send(input string tag,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ldd,
                        input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic exp_lr, input logic exp_ar);
        ld_valid = lv;  ld_rd = lrd;  ld_data = ldd;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        #1;
        check({tag, "_ld_ready"}, 32'(ld_ready), 32'(exp_lr));
        check({tag, "_alu_ready"}, 32'(alu_ready), 32'(exp_ar));
        if (lv && exp_lr && lrd != 5'd0) sb.push_back('{rd: lrd, data: ldd});
        if (av && exp_ar && ard != 5'd0) sb.push_back('{rd: ard, data: ad});
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        alu_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        tick();
        check({tag, "_drained"}, 32'(sb.size()), 32'd0);
    endtask

    // Scoreboard: each write-port cycle must match the oldest accepted result
    always @(negedge clk) begin
        if (!reset && rf_we) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL unexpected_write observed rd=%0d data=0x%0h expected no write", rf_waddr, rf_wdata);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("sb_waddr", 32'(rf_waddr), 32'(e.rd));
                check("sb_wdata", rf_wdata, e.data);
            end
        end
    end

    initial begin
        reset = 1'b1; hold = 1'b0;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        q_rs1 = 5'd5; q_rs2 = 5'd0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_rf_we", 32'(rf_we), 0);
        check("rst_rf_waddr", 32'(rf_waddr), 0);
        check("rst_rf_wdata", rf_wdata, 0);
        check("rst_ld_ready", 32'(ld_ready), 1);
        check("rst_alu_ready", 32'(alu_ready), 1);
        check("rst_rs1_busy", 32'(rs1_busy), 0);
        check("rst_fwd_valid", 32'(rs1_fwd_valid), 0);

        // Single ALU result: latency and busy window
        send("t1", 0, 0, 0, 1, 5'd5, 32'h1234, 1, 1);
        check("t1_we_E", 32'(rf_we), 0);
        check("t1_busy_E", 32'(rs1_busy), 1);
        tick();
        check("t1_we_E1", 32'(rf_we), 1);
        check("t1_waddr_E1", 32'(rf_waddr), 5);
        check("t1_wdata_E1", rf_wdata, 32'h1234);
        check("t1_busy_E1", 32'(rs1_busy), 1);
        tick();
        check("t1_we_E2", 32'(rf_we), 0);
        check("t1_busy_E2", 32'(rs1_busy), 0);
        check("t1_waddr_kept", 32'(rf_waddr), 5);

        // Dual push: load before ALU on consecutive cycles
        send("t2", 1, 5'd3, 32'hAA, 1, 5'd4, 32'hBB, 1, 1);
        check("t2_we_E", 32'(rf_we), 0);
        tick();
        check("t2_waddr0", 32'(rf_waddr), 3);
        tick();
        check("t2_waddr1", 32'(rf_waddr), 4);
        check("t2_we1", 32'(rf_we), 1);
        tick();
        check("t2_we_off", 32'(rf_we), 0);

        // Fill under hold, then release with a mid-stream re-hold
        hold = 1'b1;
        send("t3a", 1, 5'd10, 32'h100, 1, 5'd11, 32'h110, 1, 1);
        send("t3b", 1, 5'd12, 32'h120, 1, 5'd13, 32'h130, 1, 1);
        check("t3_full_ld_ready", 32'(ld_ready), 0);
        check("t3_full_alu_ready", 32'(alu_ready), 0);
        check("t3_hold_we", 32'(rf_we), 0);
        q_rs1 = 5'd13; q_rs2 = 5'd10;
        #1;
        check("t3_rs1_busy", 32'(rs1_busy), 1);
        check("t3_rs2_busy", 32'(rs2_busy), 1);
`ifdef WB_BYPASS_EN
        check("t3_rs1_fwd", rs1_fwd_data, 32'h130);
        check("t3_rs2_fwd", rs2_fwd_data, 32'h100);
`else
        check("t3_rs1_fwd_off", 32'(rs1_fwd_valid), 0);
`endif
        hold = 1'b0;
        tick();
        check("t3_w0", 32'(rf_waddr), 10);
        check("t3_ready_back", 32'(ld_ready), 1);
        tick();
        check("t3_w1", 32'(rf_waddr), 11);
        hold = 1'b1;
        tick();
        check("t3_rehold_we", 32'(rf_we), 0);
        check("t3_rehold_waddr", 32'(rf_waddr), 11);
        hold = 1'b0;
        tick();
        check("t3_w2", 32'(rf_waddr), 12);
        tick();
        check("t3_w3", 32'(rf_waddr), 13);
        check("t3_w3_we", 32'(rf_we), 1);
        tick();
        check("t3_done_we", 32'(rf_we), 0);

        // Count 3 with both valid: ALU must wait for space
        hold = 1'b1;
        send("t4a", 1, 5'd20, 32'h200, 1, 5'd21, 32'h210, 1, 1);
        send("t4b", 1, 5'd22, 32'h220, 0, 5'd0, 32'h0, 1, 1);
        send("t4c", 1, 5'd23, 32'h230, 1, 5'd24, 32'h240, 1, 0);
        hold = 1'b0;
        tick();
        send("t4d", 0, 5'd0, 32'h0, 1, 5'd24, 32'h240, 1, 1);
        drain("t4");

        // x0 result: handshake only, nothing written or busy
        q_rs1 = 5'd0;
        send("t5", 0, 0, 0, 1, 5'd0, 32'hFFFF, 1, 1);
        check("t5_we", 32'(rf_we), 0);
        check("t5_busy", 32'(rs1_busy), 0);
        tick();
        check("t5_we_later", 32'(rf_we), 0);

        // Same rd twice: youngest data forwarded; reset drops everything
        hold = 1'b1;
        q_rs1 = 5'd7; q_rs2 = 5'd8;
        send("t6a", 0, 0, 0, 1, 5'd7, 32'h1, 1, 1);
        send("t6b", 0, 0, 0, 1, 5'd7, 32'h2, 1, 1);
        check("t6_busy", 32'(rs1_busy), 1);
        check("t6_rs2_idle", 32'(rs2_busy), 0);
`ifdef WB_BYPASS_EN
        check("t6_fwd_valid", 32'(rs1_fwd_valid), 1);
        check("t6_fwd_data", rs1_fwd_data, 32'h2);
`else
        check("t6_fwd_off", 32'(rs1_fwd_valid), 0);
`endif
        hold = 1'b0;
        tick();
        check("t6_pop_we", 32'(rf_we), 1);
`ifdef WB_BYPASS_EN
        check("t6_fwd_younger", rs1_fwd_data, 32'h2);
`endif
        reset = 1'b1;
        #1;
        sb.delete();
        check("t6_rst_we", 32'(rf_we), 0);
        check("t6_rst_waddr", 32'(rf_waddr), 0);
        check("t6_rst_busy", 32'(rs1_busy), 0);
        check("t6_rst_fwd", 32'(rs1_fwd_valid), 0);
        tick(); tick();
        reset = 1'b0;
        tick(); tick();
        check("t6_after_we", 32'(rf_we), 0);
        check("t6_after_busy", 32'(rs1_busy), 0);
        check("t6_after_ready", 32'(alu_ready), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
